ahb_bram_ctrl: RTL

- AHB-Lite slave that is the initiator side of the dual-port program/data block RAM.
- Converts CPU (Cortex-M0) bus transfers into RAM write-port signals (addra/dina/wea) and read-port signals (addrb/doutb).
- Zero-wait-state reads and writes, with byte/halfword/word byte-lane generation.
- Forwards pending write data so a read immediately after a write returns new data.
- Sits between the AHB interconnect and the block RAM instance.

---
 rtl/ahb_bram_ctrl_pkg.sv | 23 ++
 rtl/ahb_bram_ctrl_bytemask_gen.sv | 24 ++
 rtl/ahb_bram_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ahb_bram_ctrl_pkg.sv
// Shared encodings for the AHB-Lite block-RAM controller: bus transfer/size/response
// codes and the error-response state machine encoding.
package ahb_bram_ctrl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_e;

endpackage

// File: rtl/ahb_bram_ctrl_bytemask_gen.sv
// Byte-lane enable generator: maps transfer size and low address bits to a 4-bit
// lane mask, flagging sizes wider than a word as illegal.
module ahb_bytemask_gen
    import ahb_bram_ctrl_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] haddr_lo,
    output logic [3:0] mask,
    output logic       illegal
);

    // Lane decode; illegal sizes produce an empty mask so no RAM lane can fire.
    always_comb begin
        mask    = 4'b0000;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << haddr_lo;
            HSIZE_HALF: mask = 4'b0011 << {haddr_lo[1], 1'b0};
            HSIZE_WORD: mask = 4'b1111;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave driving the write and read ports of a dual-port block RAM with
// zero wait states, byte-lane writes and write-to-read data forwarding.
module ahb_bram_ctrl
    import ahb_bram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [31:0]           dina,
    output logic [3:0]            wea,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [31:0]           doutb
);

    logic                  acc_s;
    logic                  illegal_s;
    logic                  fwd_hit_s;
    logic [3:0]            mask_s;
    logic [3:0]            wea_s;
    logic [31:0]           hrdata_s;
    logic [ADDR_WIDTH-1:0] haddr_word_s;
    logic                  unused_s;

    err_state_e            state_r;
    err_state_e            state_nxt_s;
    logic                  wr_pend_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [3:0]            mask_r;
    logic [3:0]            fwd_mask_r;
    logic [31:0]           fwd_data_r;
    logic                  hreadyout_r;
    logic                  hresp_r;

    assign acc_s        = HSEL & HREADY & HTRANS[1];
    assign haddr_word_s = HADDR[ADDR_WIDTH+1:2];
    assign unused_s     = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    // RAM read-old-on-collision: a read of the word being written this cycle must take new lanes from HWDATA.
    assign fwd_hit_s = acc_s & ~HWRITE & ~illegal_s & wr_pend_r & (haddr_word_s == addr_r);

    ahb_bytemask_gen u_bytemask (
        .hsize    (HSIZE),
        .haddr_lo (HADDR[1:0]),
        .mask     (mask_s),
        .illegal  (illegal_s)
    );

    // Address-phase capture and forwarding snapshot.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend_r  <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            mask_r     <= 4'b0000;
            fwd_mask_r <= 4'b0000;
            fwd_data_r <= 32'h0000_0000;
        end else begin
            wr_pend_r <= acc_s & HWRITE & ~illegal_s;
            if (acc_s) begin
                addr_r <= haddr_word_s;
                mask_r <= mask_s;
            end
            fwd_mask_r <= fwd_hit_s ? wea_s : 4'b0000;
            if (fwd_hit_s) begin
                fwd_data_r <= HWDATA;
            end
        end
    end

    // Write enables only during a legal write data phase.
    always_comb begin
        wea_s = 4'b0000;
        if (wr_pend_r) begin
            wea_s = mask_r;
        end else begin
            wea_s = 4'b0000;
        end
    end

    // Per-lane merge of forwarded write data over the registered RAM output.
    always_comb begin
        hrdata_s = doutb;
        for (int i = 0; i < 4; i++) begin
            if (fwd_mask_r[i]) begin
                hrdata_s[8*i +: 8] = fwd_data_r[8*i +: 8];
            end else begin
                hrdata_s[8*i +: 8] = doutb[8*i +: 8];
            end
        end
    end

    // Error-response next state; an illegal transfer in ERR2 restarts the two-cycle response.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s && illegal_s) begin
                    state_nxt_s = ST_ERR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            ST_ERR2: begin
                if (acc_s && illegal_s) begin
                    state_nxt_s = ST_ERR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register with response outputs registered from the next state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_nxt_s;
            hreadyout_r <= (state_nxt_s != ST_ERR1);
            hresp_r     <= (state_nxt_s == ST_IDLE) ? HRESP_OKAY : HRESP_ERROR;
        end
    end

    assign addra     = addr_r;
    assign dina      = HWDATA;
    assign wea       = wea_s;
    assign addrb     = haddr_word_s;
    assign HRDATA    = hrdata_s;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;

endmodule
